// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer: holds one 64-byte line from addr_to_data and streams
// 32-bit instructions to decode over a valid/ready handshake. Misses issue a
// single-cycle line-fill request and wait for fill_ready. Redirects retarget
// the PC in any state. A fill that is already in flight always runs to
// completion, because addr_to_data cannot abort one.
// Optional build macro FETCH_STATS_EN adds the fill_count and served_count
// outputs.
module fetch_line_buffer #(
  parameter int BUS_DATA_WIDTH    = 64,
  parameter int LINE_WIDTH        = BUS_DATA_WIDTH * 8,
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BUS_DATA_WIDTH-1:0]    entry_pc,
  output logic                         fill_enable,
  output logic [BUS_DATA_WIDTH-1:0]    fill_addr,
  input  logic                         fill_ready,
  input  logic [LINE_WIDTH-1:0]        fill_data,
  input  logic                         redirect_valid,
  input  logic [BUS_DATA_WIDTH-1:0]    redirect_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic [BUS_DATA_WIDTH-1:0]    instr_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                  fill_count,
  output logic [31:0]                  served_count
`endif
);

  localparam int TAG_W = BUS_DATA_WIDTH - 6;
  localparam logic [BUS_DATA_WIDTH-1:0] ALIGN_MASK = ~BUS_DATA_WIDTH'(3);

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    FILL_REQ  = 2'd1,
    FILL_WAIT = 2'd2
  } state_t;

  state_t                      state;
  logic [BUS_DATA_WIDTH-1:0]   pc;
  logic                        line_valid;
  logic [TAG_W-1:0]            line_tag;
  logic [LINE_WIDTH-1:0]       line;
  logic                        hit;
  logic                        fire;
  logic [INSTRUCTION_WIDTH-1:0] word;

  // Hit detect and instruction selection. Outputs read as zero whenever
  // nothing is being offered, so that instr and instr_pc are clean after reset.
  always_comb begin
    hit         = line_valid && (line_tag == pc[BUS_DATA_WIDTH-1:6]);
    word        = line[{pc[5:2], 5'd0} +: INSTRUCTION_WIDTH];
    instr_valid = (state == SERVE) && hit && !redirect_valid;
    instr       = instr_valid ? word : '0;
    instr_pc    = instr_valid ? pc : '0;
    fire        = instr_valid && instr_ready;
  end

  // PC tracking, the fill FSM and the line storage. A redirect takes priority
  // over a sequential advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= SERVE;
      pc          <= entry_pc & ALIGN_MASK;
      line_valid  <= 1'b0;
      line_tag    <= '0;
      line        <= '0;
      fill_enable <= 1'b0;
      fill_addr   <= '0;
    end else begin
      if (redirect_valid)
        pc <= redirect_pc & ALIGN_MASK;
      else if (fire)
        pc <= pc + BUS_DATA_WIDTH'(4);

      case (state)
        SERVE: begin
          if (!hit && !redirect_valid) begin
            state       <= FILL_REQ;
            fill_enable <= 1'b1;
            fill_addr   <= {pc[BUS_DATA_WIDTH-1:6], 6'b0};
          end
        end
        FILL_REQ: begin
          fill_enable <= 1'b0;
          state       <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (fill_ready) begin
            line       <= fill_data;
            line_tag   <= fill_addr[BUS_DATA_WIDTH-1:6];
            line_valid <= 1'b1;
            state      <= SERVE;
          end
        end
        default: begin
          fill_enable <= 1'b0;
          state       <= SERVE;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  // Free-running wrap-around counters of fill requests and accepted instructions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_count   <= '0;
      served_count <= '0;
    end else begin
      if (state == FILL_REQ)
        fill_count <= fill_count + 32'd1;
      if (fire)
        served_count <= served_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed testbench for fetch_line_buffer: cold start, streaming, backpressure,
// redirects in SERVE and during a fill, and reset during an in-flight fill.
module tb_fetch_line_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  entry_pc;
  logic         fill_enable;
  logic [63:0]  fill_addr;
  logic         fill_ready;
  logic [511:0] fill_data;
  logic         redirect_valid;
  logic [63:0]  redirect_pc;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [63:0]  instr_pc;
`ifdef FETCH_STATS_EN
  logic [31:0]  fill_count;
  logic [31:0]  served_count;
`endif

  int checks = 0;
  int errors = 0;

  fetch_line_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .entry_pc       (entry_pc),
    .fill_enable    (fill_enable),
    .fill_addr      (fill_addr),
    .fill_ready     (fill_ready),
    .fill_data      (fill_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef FETCH_STATS_EN
    ,
    .fill_count     (fill_count),
    .served_count   (served_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] mk_line(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are checked 1 time unit later.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] bogus;
    bogus = {16{32'hDEAD_BEEF}};

    reset          = 1'b0;
    entry_pc       = 64'h1000;
    fill_ready     = 1'b0;
    fill_data      = bogus;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    instr_ready    = 1'b0;

    // Reset state
    cyc; cyc; #1;
    chk("rst_fill_enable", 64'(fill_enable), 64'd0);
    chk("rst_fill_addr", fill_addr, 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);
    reset = 1'b1;

    // Cold start: FILL_REQ, with a fill_ready that must be ignored
    cyc;
    fill_ready = 1'b1; fill_data = bogus; #1;
    chk("cold_fill_enable", 64'(fill_enable), 64'd1);
    chk("cold_fill_addr", fill_addr, 64'h1000);
    chk("cold_req_valid", 64'(instr_valid), 64'd0);

    cyc;
    fill_ready = 1'b0; #1;
    chk("wait_fill_enable", 64'(fill_enable), 64'd0);
    chk("wait_fill_addr_held", fill_addr, 64'h1000);
    chk("wait_valid", 64'(instr_valid), 64'd0);

    cyc;
    fill_ready = 1'b1; fill_data = mk_line(32'hA000_0000); #1;
    chk("wait2_valid", 64'(instr_valid), 64'd0);

    cyc;
    fill_ready = 1'b0; fill_data = bogus; instr_ready = 1'b0; #1;
    chk("first_valid", 64'(instr_valid), 64'd1);
    chk("first_instr", 64'(instr), 64'hA000_0000);
    chk("first_pc", instr_pc, 64'h1000);

    // Redirect that hits the buffered line; low PC bits are dropped
    cyc;
    redirect_valid = 1'b1; redirect_pc = 64'h1023; instr_ready = 1'b1; #1;
    chk("redir_valid_low", 64'(instr_valid), 64'd0);

    cyc;
    redirect_valid = 1'b0; instr_ready = 1'b0; #1;
    chk("redir_hit_valid", 64'(instr_valid), 64'd1);
    chk("redir_hit_pc", instr_pc, 64'h1020);
    chk("redir_hit_instr", 64'(instr), 64'hA000_0008);
    chk("redir_hit_nofill", 64'(fill_enable), 64'd0);

    // Move to 0x1008, then hold backpressure for five cycles
    cyc;
    redirect_valid = 1'b1; redirect_pc = 64'h1008; #1;
    chk("redir2_valid_low", 64'(instr_valid), 64'd0);
    cyc;
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc;
      #1;
      chk("bp_valid", 64'(instr_valid), 64'd1);
      chk("bp_instr", 64'(instr), 64'hA000_0002);
      chk("bp_pc", instr_pc, 64'h1008);
    end

    // Streaming to the end of the line, one instruction per cycle
    instr_ready = 1'b1;
    for (int k = 3; k < 16; k++) begin
      cyc;
      chk("stream_valid", 64'(instr_valid), 64'd1);
      chk("stream_pc", instr_pc, 64'h1000 + 64'(4 * k));
      chk("stream_instr", 64'(instr), 64'hA000_0000 + 64'(k));
    end

    // Line crossing: miss, then a fill request for 0x1040
    cyc;
    chk("cross_valid", 64'(instr_valid), 64'd0);
    chk("cross_no_req_yet", 64'(fill_enable), 64'd0);
    cyc;
    chk("cross_fill_enable", 64'(fill_enable), 64'd1);
    chk("cross_fill_addr", fill_addr, 64'h1040);
    chk("cross_req_valid", 64'(instr_valid), 64'd0);

    // Redirect to 0x2000 while the 0x1040 fill is pending
    cyc;
    redirect_valid = 1'b1; redirect_pc = 64'h2000; #1;
    chk("fw_redir_enable", 64'(fill_enable), 64'd0);
    chk("fw_redir_valid", 64'(instr_valid), 64'd0);
    cyc;
    redirect_valid = 1'b0; fill_ready = 1'b1; fill_data = mk_line(32'hB000_0000); #1;
    chk("fw_ready_valid", 64'(instr_valid), 64'd0);
    chk("fw_addr_held", fill_addr, 64'h1040);
    cyc;
    fill_ready = 1'b0; fill_data = bogus; #1;
    chk("fw_after_valid", 64'(instr_valid), 64'd0);
    chk("fw_after_enable", 64'(fill_enable), 64'd0);
    cyc;
    chk("refill_enable", 64'(fill_enable), 64'd1);
    chk("refill_addr", fill_addr, 64'h2000);
    chk("refill_valid", 64'(instr_valid), 64'd0);
    cyc;
    fill_ready = 1'b1; fill_data = mk_line(32'hC000_0000); #1;
    cyc;
    fill_ready = 1'b0; fill_data = bogus; instr_ready = 1'b0; #1;
    chk("line2_valid", 64'(instr_valid), 64'd1);
    chk("line2_instr", 64'(instr), 64'hC000_0000);
    chk("line2_pc", instr_pc, 64'h2000);

    // Reset while a fill for 0x3000 is in flight
    cyc;
    redirect_valid = 1'b1; redirect_pc = 64'h3000; #1;
    cyc;
    redirect_valid = 1'b0; #1;
    chk("r_miss_valid", 64'(instr_valid), 64'd0);
    cyc;
    chk("r_req_addr", fill_addr, 64'h3000);
    cyc;
    reset = 1'b0; entry_pc = 64'h4002; #1;
    cyc;
    chk("rmid_fill_enable", 64'(fill_enable), 64'd0);
    chk("rmid_fill_addr", fill_addr, 64'd0);
    chk("rmid_instr_valid", 64'(instr_valid), 64'd0);
    chk("rmid_instr", 64'(instr), 64'd0);
    chk("rmid_instr_pc", instr_pc, 64'd0);
`ifdef FETCH_STATS_EN
    chk("rmid_fill_count", 64'(fill_count), 64'd0);
    chk("rmid_served_count", 64'(served_count), 64'd0);
`endif
    reset = 1'b1;
    cyc;
    chk("post_fill_enable", 64'(fill_enable), 64'd1);
    chk("post_fill_addr", fill_addr, 64'h4000);
    cyc;
    fill_ready = 1'b1; fill_data = mk_line(32'hD000_0000); #1;
`ifdef FETCH_STATS_EN
    chk("post_fill_count", 64'(fill_count), 64'd1);
`endif
    cyc;
    fill_ready = 1'b0; fill_data = bogus; #1;
    chk("post_valid", 64'(instr_valid), 64'd1);
    chk("post_instr", 64'(instr), 64'hD000_0000);
    chk("post_pc", instr_pc, 64'h4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
